// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, receiver FSM states and
// a parameter-legality helper used at elaboration time.
package uart_pkg;

  // Parity (check) mode encodings, shared by receiver and transmitter
  localparam int CHK_NONE = 0;
  localparam int CHK_EVEN = 1;
  localparam int CHK_ODD  = 2;
  localparam int CHK_ZERO = 3;
  localparam int CHK_ONE  = 4;

  // Receiver frame FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Returns 1 when the receiver parameter set is legal
  function automatic bit uart_rx_params_ok(
    input int clk_div,
    input int oversample,
    input int data_bits,
    input int check_mode,
    input int stop_bits,
    input int fifo_depth
  );
    bit ok;
    ok = 1'b1;
    if (clk_div < 1) ok = 1'b0;
    if ((oversample < 8) || ((oversample % 2) != 0)) ok = 1'b0;
    if ((data_bits < 5) || (data_bits > 9)) ok = 1'b0;
    if ((check_mode < CHK_NONE) || (check_mode > CHK_ONE)) ok = 1'b0;
    if ((stop_bits != 1) && (stop_bits != 2)) ok = 1'b0;
    if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous first-word-fall-through FIFO holding received words.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Word storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, configurable
// framing, false-start rejection and a FWFT output buffer of flagged words.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int CHECK_MODE = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 data_out_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  output logic                 check_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLE / 2;
  localparam int WW = DATA_BITS + 2;

  if (!uart_rx_params_ok(CLK_DIV, OVERSAMPLE, DATA_BITS, CHECK_MODE, STOP_BITS, FIFO_DEPTH))
  begin : g_bad_params
    $error("uart_rx_os: illegal parameter combination");
  end

  // Expected parity bit for the received data in the configured mode
  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
    logic p;
    case (CHECK_MODE)
      CHK_EVEN: p = ^d;
      CHK_ODD:  p = ~^d;
      CHK_ONE:  p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 hist_q;
  rx_state_e            state_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [OW-1:0]        os_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 chk_err_q;
  logic                 frm_err_q;
  logic                 push_q;
  logic                 brk_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_vote_q;
  logic [WW-1:0]        word_q;

  logic                 start_edge;
  logic                 tick;
  logic                 bit_end;
  logic                 vote_tick;
  logic                 vote;
  logic                 last_data;
  logic                 last_stop;
  logic                 frm_d;
  logic                 brk_d;
  logic                 word_done;

  logic [WW-1:0]        head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  // Bring rx into the clock domain and keep one bit of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign start_edge = hist_q && !sync2_q;
  assign tick       = (state_q != IDLE) && (clk_cnt_q == CW'(CLK_DIV - 1));
  assign bit_end    = tick && (os_cnt_q == OW'(OVERSAMPLE - 1));
  assign vote_tick  = tick && (os_cnt_q == OW'(M + 1));
  // The third sample is the live synchronised value on the vote tick
  assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
  assign last_data  = (bit_cnt_q == BW'(DATA_BITS - 1));
  assign last_stop  = (stop_cnt_q == 1'(STOP_BITS - 1));
  assign frm_d      = frm_err_q | ~vote;
  assign brk_d      = (data_q == '0) && ((CHECK_MODE == CHK_NONE) || !par_vote_q) && frm_d;
  // The word completes mid-way through the last stop bit so a back-to-back start is not missed
  assign word_done  = rx_en && (state_q == STOP) && vote_tick && last_stop;

  // Frame FSM, sample timing counters and per-word error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      chk_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      push_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      push_q <= word_done;
      brk_q  <= word_done && brk_d;
      if (!rx_en || (state_q == IDLE)) begin
        clk_cnt_q  <= '0;
        os_cnt_q   <= '0;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        chk_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
        state_q    <= (rx_en && start_edge) ? START : IDLE;
      end else begin
        clk_cnt_q <= tick ? '0 : clk_cnt_q + CW'(1);
        if (tick) os_cnt_q <= bit_end ? '0 : os_cnt_q + OW'(1);
        case (state_q)
          START: begin
            if (vote_tick && vote) state_q <= IDLE;
            else if (bit_end)      state_q <= DATA;
          end
          DATA: begin
            if (bit_end) begin
              if (last_data) begin
                bit_cnt_q <= '0;
                state_q   <= (CHECK_MODE != CHK_NONE) ? PARITY : STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end
          end
          PARITY: begin
            if (vote_tick && (vote != exp_parity(data_q))) chk_err_q <= 1'b1;
            if (bit_end) state_q <= STOP;
          end
          STOP: begin
            if (vote_tick) begin
              frm_err_q <= frm_d;
              if (last_stop) state_q <= IDLE;
            end else if (bit_end) begin
              stop_cnt_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Sample capture, data shift-in and completed-word assembly
  always_ff @(posedge clk) begin
    if (tick && (os_cnt_q == OW'(M - 1))) smp_q[0] <= sync2_q;
    if (tick && (os_cnt_q == OW'(M)))     smp_q[1] <= sync2_q;
    if (vote_tick && (state_q == DATA))   data_q[bit_cnt_q] <= vote;
    if (vote_tick && (state_q == PARITY)) par_vote_q <= vote;
    if (word_done)                        word_q <= {frm_d, chk_err_q, data_q};
  end

  uart_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i (word_q),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign data_out_valid = !fifo_empty;
  assign pop            = data_out_valid && data_out_ready;
  assign overrun        = push_q && fifo_full && !pop;
  assign break_det      = brk_q;
  assign busy           = (state_q != IDLE);
  assign data_out       = data_out_valid ? head[DATA_BITS-1:0] : '0;
  assign check_err      = data_out_valid && head[DATA_BITS];
  assign frame_err      = data_out_valid && head[DATA_BITS+1];

endmodule
